// File: rtl/way_index_decoder.sv
// Registered 3-to-8 way-index decoder with a small FIFO between the tag and data phases.
// The one-hot vector is decoded when an entry is accepted and stored with it.
module way_index_decoder #(
  parameter int unsigned WAYS  = 8,
  parameter int unsigned IDX_W = 3,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_enable,
  input  logic [IDX_W-1:0] in_way,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WAYS-1:0]  out_onehot,
  output logic [IDX_W-1:0] out_way,
  output logic             out_hit
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WAYS-1:0]  mem_onehot [DEPTH];
  logic [IDX_W-1:0] mem_way    [DEPTH];
  logic             mem_hit    [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic             push;
  logic             pop;
  logic [WAYS-1:0]  decoded;

  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // An out-of-range index simply matches no bit, giving an all-zero vector.
  always_comb begin
    decoded = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      decoded[i] = in_enable && (in_way == IDX_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && push) begin
      mem_onehot[wr_ptr] <= decoded;
      mem_way[wr_ptr]    <= in_way;
      mem_hit[wr_ptr]    <= in_enable;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    out_onehot = '0;
    out_way    = '0;
    out_hit    = 1'b0;
    if (out_valid) begin
      out_onehot = mem_onehot[rd_ptr];
      out_way    = mem_way[rd_ptr];
      out_hit    = mem_hit[rd_ptr];
    end
  end

endmodule

// File: tb/tb_way_index_decoder.sv
// Directed self-checking bench for way_index_decoder (WAYS=8, IDX_W=3, DEPTH=2).
module tb_way_index_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic       in_enable;
  logic [2:0] in_way;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_onehot;
  logic [2:0] out_way;
  logic       out_hit;

  int n_cmp = 0;
  int n_err = 0;

  way_index_decoder #(.WAYS(8), .IDX_W(3), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_enable(in_enable), .in_way(in_way), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_onehot(out_onehot), .out_way(out_way), .out_hit(out_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic en, input logic [2:0] w, input logic rdy);
    in_valid  = v;
    in_enable = en;
    in_way    = w;
    out_ready = rdy;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"},  out_valid,  0);
    chk({tag, "_onehot"}, out_onehot, 0);
    chk({tag, "_way"},    out_way,    0);
    chk({tag, "_hit"},    out_hit,    0);
  endtask

  task automatic chk_head(input string tag, input logic [7:0] oh, input logic [2:0] w, input logic h);
    chk({tag, "_valid"},  out_valid,  1);
    chk({tag, "_onehot"}, out_onehot, oh);
    chk({tag, "_way"},    out_way,    w);
    chk({tag, "_hit"},    out_hit,    h);
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    drive(0, 0, 3'd0, 0);
    step();
    step();
    reset = 1'b0;
    chk_empty("rst");
    chk("rst_in_ready", in_ready, 1);

    // single push of way 5
    drive(1, 1, 3'd5, 1);
    step();
    drive(0, 0, 3'd0, 1);
    chk_head("w5", 8'b0010_0000, 3'd5, 1);
    step();
    chk("w5_gone", out_valid, 0);

    // fill with way 7 (hit) and way 2 (no hit), stall
    drive(1, 1, 3'd7, 0);
    step();
    drive(1, 0, 3'd2, 0);
    step();
    drive(0, 0, 3'd0, 0);
    chk("full_in_ready", in_ready, 0);
    for (int i = 0; i < 5; i++) begin
      chk_head("stall", 8'b1000_0000, 3'd7, 1);
      step();
    end
    chk_head("stall_last", 8'b1000_0000, 3'd7, 1);
    out_ready = 1'b1;
    step();
    chk_head("miss", 8'b0000_0000, 3'd2, 0);
    chk("ready_after_pop", in_ready, 1);
    step();
    chk("drain", out_valid, 0);

    // full with simultaneous push attempt and pop
    drive(1, 1, 3'd1, 0);
    step();
    drive(1, 1, 3'd3, 0);
    step();
    drive(1, 1, 3'd6, 1);
    chk("fullpp_in_ready", in_ready, 0);
    step();
    chk_head("fullpp_head", 8'h08, 3'd3, 1);
    chk("fullpp_ready_next", in_ready, 1);
    drive(1, 1, 3'd6, 0);
    step();
    chk_head("fullpp_hold", 8'h08, 3'd3, 1);
    drive(0, 0, 3'd0, 1);
    step();
    chk_head("fullpp_new", 8'h40, 3'd6, 1);
    step();
    chk("fullpp_drain", out_valid, 0);

    // continuous stream through pointer wrap
    for (int k = 0; k < 8; k++) begin
      drive(1, 1, 3'(k), 1);
      step();
      chk_head("stream", 8'(1 << k), 3'(k), 1);
      chk("stream_ready", in_ready, 1);
    end
    drive(0, 0, 3'd0, 1);
    step();
    chk("stream_drain", out_valid, 0);

    // flush with two queued entries and a concurrent push attempt
    drive(1, 1, 3'd0, 0);
    step();
    drive(1, 1, 3'd3, 0);
    step();
    drive(1, 1, 3'd4, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(0, 0, 3'd0, 0);
    chk_empty("flush");
    chk("flush_in_ready", in_ready, 1);
    step();
    chk("flush_no_w4", out_valid, 0);
    drive(1, 1, 3'd1, 0);
    step();
    drive(0, 0, 3'd0, 1);
    chk_head("post_flush", 8'h02, 3'd1, 1);
    step();
    chk("post_flush_drain", out_valid, 0);

    // flush discards a push accepted in the same cycle
    drive(1, 1, 3'd5, 0);
    step();
    drive(1, 1, 3'd4, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(0, 0, 3'd0, 1);
    chk_empty("flush_push");
    step();
    chk("flush_push_later", out_valid, 0);

    // reset mid-stall with two queued entries
    drive(1, 1, 3'd6, 0);
    step();
    drive(1, 1, 3'd2, 0);
    step();
    drive(0, 0, 3'd0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_empty("midrst");
    chk("midrst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midrst_stays_empty", out_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
